// File: rtl/pattern_tx_pkg.sv
// Shared types and default sizing for the pattern transmitter.
package pattern_tx_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int GAP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/pattern_tx_match.sv
// Counts overlapping occurrences of the job pattern in the transmitted bit stream.
module pattern_tx_match #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [PAT_W-1:0] pat,
  input  logic             x,
  input  logic             x_vld,
  output logic [CNT_W-1:0] cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  win;
  logic [PAT_W-1:0]  nxt;
  logic [FILL_W-1:0] fill;
  logic              full;
  logic              hit;

  assign nxt  = PAT_W'({win, x});
  // window is only comparable once it holds PAT_W real stream bits
  assign full = (fill >= FILL_W'(PAT_W - 1));
  assign hit  = x_vld && full && (nxt == pat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win  <= '0;
      fill <= '0;
      cnt  <= '0;
    end else if (clr) begin
      win  <= '0;
      fill <= '0;
      cnt  <= '0;
    end else if (x_vld) begin
      win <= nxt;
      if (fill != FILL_W'(PAT_W)) fill <= fill + FILL_W'(1);
      if (hit && (cnt != '1)) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends pat MSB-first reps times with gap zero bits between.
// Optional match counter output exp_cnt is built when PATTERN_TX_EXP_CNT_EN is defined.
module pattern_tx
  import pattern_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             ready,
  output logic             x,
  output logic             x_vld,
  output logic             done
`ifdef PATTERN_TX_EXP_CNT_EN
  ,output logic [CNT_W-1:0] exp_cnt
`endif
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] PAT_MSB = IDX_W'(PAT_W - 1);

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_r, pat_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [GAP_W-1:0] gap_r, gap_n;
  logic [GAP_W-1:0] gcnt, gcnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             x_n, vld_n, done_n;

  assign ready = (state == IDLE);

  // outputs are computed for the next state so x/x_vld/done line up with state
  always_comb begin
    state_n = state;
    pat_n   = pat_r;
    rem_n   = rem;
    gap_n   = gap_r;
    gcnt_n  = gcnt;
    idx_n   = idx;
    x_n     = 1'b0;
    vld_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pat_n = pat;
          rem_n = reps;
          gap_n = gap;
          if (reps == '0) begin
            state_n = FIN;
            done_n  = 1'b1;
          end else begin
            state_n = SEND;
            idx_n   = PAT_MSB;
            x_n     = pat[PAT_W-1];
            vld_n   = 1'b1;
          end
        end
      end
      SEND: begin
        if (idx != '0) begin
          idx_n = idx - IDX_W'(1);
          x_n   = pat_r[idx_n];
          vld_n = 1'b1;
        end else if (rem > CNT_W'(1)) begin
          rem_n = rem - CNT_W'(1);
          vld_n = 1'b1;
          if (gap_r != '0) begin
            state_n = GAP;
            gcnt_n  = gap_r - GAP_W'(1);
          end else begin
            idx_n = PAT_MSB;
            x_n   = pat_r[PAT_W-1];
          end
        end else begin
          state_n = FIN;
          rem_n   = '0;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        vld_n = 1'b1;
        if (gcnt != '0) begin
          gcnt_n = gcnt - GAP_W'(1);
        end else begin
          state_n = SEND;
          idx_n   = PAT_MSB;
          x_n     = pat_r[PAT_W-1];
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pat_r <= '0;
      rem   <= '0;
      gap_r <= '0;
      gcnt  <= '0;
      idx   <= '0;
      x     <= 1'b0;
      x_vld <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      pat_r <= pat_n;
      rem   <= rem_n;
      gap_r <= gap_n;
      gcnt  <= gcnt_n;
      idx   <= idx_n;
      x     <= x_n;
      x_vld <= vld_n;
      done  <= done_n;
    end
  end

`ifdef PATTERN_TX_EXP_CNT_EN
  pattern_tx_match #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_match (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start && ready),
    .pat   (pat_r),
    .x     (x),
    .x_vld (x_vld),
    .cnt   (exp_cnt)
  );
`endif

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized self-checking bench for pattern_tx against a stream-level reference model.
module tb_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [PAT_W-1:0] pat;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             ready, x, x_vld, done;
`ifdef PATTERN_TX_EXP_CNT_EN
  logic [CNT_W-1:0] exp_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .pat   (pat),
    .reps  (reps),
    .gap   (gap),
    .ready (ready),
    .x     (x),
    .x_vld (x_vld),
    .done  (done)
`ifdef PATTERN_TX_EXP_CNT_EN
    ,.exp_cnt (exp_cnt)
`endif
  );

  // Reference: expected bit stream, acceptance-to-done latency, overlapping match count.
  task automatic model(input logic [PAT_W-1:0] p, input int r, input int g,
                       output bit q[$], output int lat, output int cnt);
    bit ok;
    q = {};
    for (int k = 0; k < r; k++) begin
      for (int b = PAT_W - 1; b >= 0; b--) q.push_back(p[b]);
      if (k < r - 1) for (int z = 0; z < g; z++) q.push_back(1'b0);
    end
    lat = (r == 0) ? 1 : q.size() + 1;
    cnt = 0;
    for (int i = PAT_W - 1; i < q.size(); i++) begin
      ok = 1'b1;
      for (int j = 0; j < PAT_W; j++)
        if (q[i - PAT_W + 1 + j] != p[PAT_W - 1 - j]) ok = 1'b0;
      if (ok && cnt < SAT) cnt++;
    end
  endtask

  task automatic run_job(input logic [PAT_W-1:0] p, input int r, input int g,
                         input int poke, input string name);
    bit   q[$], o[$];
    int   lat, cnt, dcyc, c, stray, obs_cnt;
    bit   bad;
    logic rdy1;
    model(p, r, g, q, lat, cnt);
    c = 0;
    while (ready !== 1'b1 && c < 50) begin @(posedge clk); #1; c++; end
    @(negedge clk);
    start = 1'b1; pat = p; reps = CNT_W'(r); gap = GAP_W'(g);
    @(posedge clk); #1;
    start = 1'b0; pat = PAT_W'($urandom); reps = CNT_W'($urandom); gap = GAP_W'($urandom);
    dcyc = -1; c = 0; stray = 0; rdy1 = 1'bx; obs_cnt = -1;
    while (dcyc < 0 && c < lat + 10) begin
      c++;
      if (c == 1) rdy1 = ready;
      if (x_vld === 1'b1) o.push_back(x);
      else if (x !== 1'b0) stray++;
      if (done === 1'b1) begin
        dcyc = c;
        if (x_vld !== 1'b0) stray++;
`ifdef PATTERN_TX_EXP_CNT_EN
        obs_cnt = int'(exp_cnt);
`endif
      end
      if (poke != 0 && c == poke) begin
        start = 1'b1; pat = ~p; reps = CNT_W'(r + 1); gap = GAP_W'(g + 1);
      end else start = 1'b0;
      if (dcyc < 0) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    vecs++;
    if (dcyc != lat) begin
      errs++; $display("FAIL %s latency: got %0d want %0d", name, dcyc, lat);
    end
    bad = (o.size() != q.size());
    if (!bad) foreach (q[i]) if (o[i] != q[i]) bad = 1'b1;
    vecs++;
    if (bad) begin
      errs++; $display("FAIL %s stream: got %0d bits %p want %0d bits %p", name, o.size(), o, q.size(), q);
    end
    vecs++;
    if (rdy1 !== 1'b0) begin
      errs++; $display("FAIL %s busy_ready: got %b want 0", name, rdy1);
    end
    vecs++;
    if (stray != 0) begin
      errs++; $display("FAIL %s idle_x: got %0d stray cycles want 0", name, stray);
    end
`ifdef PATTERN_TX_EXP_CNT_EN
    vecs++;
    if (obs_cnt != cnt) begin
      errs++; $display("FAIL %s exp_cnt: got %0d want %0d", name, obs_cnt, cnt);
    end
`endif
    @(posedge clk); #1;
    vecs++;
    if (ready !== 1'b1 || done !== 1'b0 || x_vld !== 1'b0) begin
      errs++; $display("FAIL %s post_done: ready=%b done=%b x_vld=%b want 1 0 0", name, ready, done, x_vld);
    end
`ifdef PATTERN_TX_EXP_CNT_EN
    vecs++;
    if (int'(exp_cnt) != cnt) begin
      errs++; $display("FAIL %s exp_cnt_hold: got %0d want %0d", name, exp_cnt, cnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; pat = '0; reps = '0; gap = '0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (ready !== 1'b1 || x !== 1'b0 || x_vld !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL reset: ready=%b x=%b x_vld=%b done=%b want 1 0 0 0", ready, x, x_vld, done);
    end
`ifdef PATTERN_TX_EXP_CNT_EN
    vecs++;
    if (exp_cnt !== '0) begin
      errs++; $display("FAIL reset_cnt: got %0d want 0", exp_cnt);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_job(4'b1010, 3, 0, 0, "b2b_1010");
    run_job(4'b1010, 3, 2, 0, "gap2_1010");
    run_job(PAT_W'($urandom), 0, 3, 0, "reps0");
    run_job(4'b1111, 2, 0, 0, "ones");
    run_job(4'b0000, 2, 1, 0, "zeros");
  endtask

  task automatic test_ignore_start();
    run_job(4'b1010, 3, 1, 2, "ign_send");
    run_job(4'b0110, 2, 3, 6, "ign_gap");
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    start = 1'b1; pat = 4'b1101; reps = 8'd3; gap = 4'd1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    vecs++;
    if (x !== 1'b0 || x_vld !== 1'b0 || ready !== 1'b1) begin
      errs++; $display("FAIL abort: x=%b x_vld=%b ready=%b want 0 0 1", x, x_vld, ready);
    end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done === 1'b1 || x_vld === 1'b1) seen++; end
    vecs++;
    if (seen != 0) begin
      errs++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen);
    end
    run_job(4'b1001, 2, 2, 0, "after_abort");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++)
      run_job(PAT_W'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 0, "rand");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, width of repeat count and expected-match count.
REQ-003 SHALL have parameter GAP_W, default 4, width of inter-repeat gap length.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request to send, qualified by ready.
REQ-007 SHALL have port pat  input  PAT_W  pattern, transmitted MSB first.
REQ-008 SHALL have port reps  input  CNT_W  number of pattern repetitions.
REQ-009 SHALL have port gap  input  GAP_W  number of 0 bits between consecutive repetitions.
REQ-010 SHALL have port ready  output  1  high only in IDLE.
REQ-011 SHALL have port x  output  1  serial bit stream, feeds the sequence detector input.
REQ-012 SHALL have port x_vld  output  1  x carries a stream bit this cycle.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of job.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, GAP, FIN.
REQ-015 SHALL accept a job when start && ready: register pat, reps, gap; start at any other time SHALL be ignored.
REQ-016 SHALL, on acceptance with reps==0, go IDLE->FIN with no x_vld cycles.
REQ-017 SHALL, on acceptance with reps>0, go to SEND; first bit pat[PAT_W-1] appears on x with x_vld=1 in the cycle after acceptance.
REQ-018 SHALL stay in SEND PAT_W cycles, bit index counting PAT_W-1 down to 0.
REQ-019 SHALL, after the last bit of a repetition, go to GAP if repetitions remain and gap>0, to SEND if repetitions remain and gap==0 (back-to-back), else to FIN.
REQ-020 SHALL, in GAP, drive x=0, x_vld=1 for exactly gap cycles, then return to SEND.
REQ-021 SHALL, in FIN, drive done=1, x=0, x_vld=0 for one cycle, then go to IDLE.
REQ-022 SHALL take reps*PAT_W + (reps-1)*gap + 1 cycles from acceptance to done (1 cycle when reps==0).
REQ-023 SHALL register x, x_vld and done (no combinational path from inputs); ready SHALL be decoded from state.
REQ-024 SHALL hold x=0, x_vld=0 in IDLE.
REQ-025 SHALL go IDLE on an illegal state encoding.

Reset
REQ-026 SHALL, while rst_n==0, force state=IDLE, x=0, x_vld=0, done=0, all counters 0, so ready=1.
REQ-027 SHALL abort any job when reset is asserted mid-SEND or mid-GAP; no done pulse for the aborted job.

Configuration
REQ-028 SHALL honour macro PATTERN_TX_EXP_CNT_EN.
REQ-029 With it defined: SHALL add output exp_cnt [CNT_W], the count of overlapping occurrences of the registered pattern in the last PAT_W x_vld bits, cleared on acceptance, updated on each x_vld cycle, saturating at all-ones, held after done until next acceptance.
REQ-030 Without it: port exp_cnt and all matching logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 SHALL place the state enum (IDLE, SEND, GAP, FIN) and default parameter constants in package pattern_tx_pkg.
REQ-032 SHALL implement the REQ-029 matching in a sub-module pattern_tx_match (window shift register plus compare plus saturating counter), instantiated only under PATTERN_TX_EXP_CNT_EN.

Verification
REQ-033 pat=4'b1010, reps=3, gap=0 -> x=101010101010 on 12 consecutive x_vld cycles, done 13 cycles after acceptance, exp_cnt=5.
REQ-034 pat=4'b1010, reps=3, gap=2 -> x=1010 00 1010 00 1010, done 17 cycles after acceptance, exp_cnt=3.
REQ-035 reps=0 -> done the cycle after acceptance, x_vld never high, exp_cnt=0.
REQ-036 start pulsed during SEND with different pat -> ignored, original stream completes unchanged.
REQ-037 rst_n low during 2nd SEND bit -> x=0, x_vld=0, ready=1 immediately, no done; a new job is then accepted normally.
REQ-038 pat=4'b1111, reps=2, gap=0 -> eight 1s, exp_cnt=5.
